// File: rtl/speed_trap_pkg.sv
// Shared definitions for the speed-trap controller.
// Provides the FSM state encoding, the record header and field positions, the
// speed saturation helper, and the function that packs record byte 1.
package speed_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    localparam logic [7:0] REC_HEADER      = 8'hA5;
    localparam int         REC_BYTES       = 3;
    localparam int         REC_EPASS_BIT   = 7;
    localparam int         REC_TIMEOUT_BIT = 6;
    localparam int         REC_SPEED_HI_W  = 6;
    localparam int         REC_SPEED_LO_W  = 8;
    localparam int         UART_FRAME_BITS = 10;

    // All-ones value for a result of the given width.
    function automatic logic [31:0] sat_value(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Byte 1 of the record: {epass, timeout, speed high bits}.
    function automatic logic [7:0] build_byte1(input logic epass,
                                               input logic timeout,
                                               input logic [REC_SPEED_HI_W-1:0] speed_hi);
        logic [7:0] b;
        b = '0;
        b[REC_EPASS_BIT]            = epass;
        b[REC_TIMEOUT_BIT]          = timeout;
        b[REC_SPEED_HI_W-1:0]       = speed_hi;
        return b;
    endfunction

endpackage

// File: rtl/speed_trap_uart_tx.sv
// Byte-wide 8N1 UART transmitter, LSB first, line idles high.
// Ports:
//   clk, reset_n (synchronous, active-high)
//   start  : request to send data; accepted when ready is high
//   data   : byte to send
//   ready  : a new byte can be accepted this cycle (idle, or last cycle of a
//            stop bit so consecutive frames run back-to-back)
//   busy   : a frame is on the line
//   txd    : serial line
module speed_trap_uart_tx
    import speed_trap_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       txd
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    shreg;
    logic          bit_end;
    logic          frame_end;

    assign bit_end   = (clk_cnt == '0);
    assign frame_end = busy && bit_end && (bit_idx == 4'(UART_FRAME_BITS - 1));
    assign ready     = !busy || frame_end;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            busy    <= 1'b0;
            txd     <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
        end else if (start && ready) begin
            busy    <= 1'b1;
            txd     <= 1'b0;
            clk_cnt <= CW'(CLKS_PER_BIT - 1);
            bit_idx <= '0;
            shreg   <= {1'b1, data};
        end else if (busy) begin
            if (bit_end) begin
                if (frame_end) begin
                    busy <= 1'b0;
                    txd  <= 1'b1;
                end else begin
                    // shreg refills with ones so the stop bit falls out last
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                    clk_cnt <= CW'(CLKS_PER_BIT - 1);
                end
            end else begin
                clk_cnt <= clk_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/speed_trap_top.sv
// Vehicle speed-trap controller (chip top).
// Measures sensor1 -> sensor3 travel time in 10 ms units, divides DIST_CONST
// by it to get speed in 0.1 km/h, and sends a 3-byte record over UART.
// Ports:
//   clk             : system clock
//   reset_n         : synchronous reset, active-high despite the name
//   sensor1..3      : asynchronous road sensors, high while a vehicle is over
//   valid_Epass     : e-pass tag valid, sampled at the sensor2 rising edge
//   enable          : resend the last record when idle
//   serial_data_out : UART TX line
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for sensor1 rise or a resend request
// ST_TIMING | counting t in 10 ms units, latching e-pass, waiting sensor3
// ST_DIVIDE | sequential DIST_CONST / t with saturation
// ST_SEND   | shifting the 3-byte record out on the UART
module speed_trap_top
    import speed_trap_pkg::*;
#(
    parameter int WIDTH_TIK    = 16,
    parameter int WIDTH_MS     = 9,
    parameter int WIDTH_SPEED  = 14,
    parameter int TICKS_PER_MS = 50000,
    parameter int DIST_CONST   = 72000,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor1,
    input  logic sensor2,
    input  logic sensor3,
    input  logic valid_Epass,
    input  logic enable,
    output logic serial_data_out
);

    localparam int DW    = WIDTH_MS + WIDTH_SPEED;
    localparam int CNT_W = $clog2(WIDTH_SPEED);
    localparam logic [31:0]            SAT_FULL  = sat_value(WIDTH_SPEED);
    localparam logic [WIDTH_SPEED-1:0] SPEED_SAT = SAT_FULL[WIDTH_SPEED-1:0];
    localparam logic [WIDTH_MS-1:0]    T_MAX     = '1;

    // ---------------- input synchronizers and edge detect ----------------
    logic [4:0] in_raw, sync_a, sync_b;
    logic [2:0] sens_prev;
    logic       s1_rise, s2_rise, s3_rise;
    logic       valid_sync, enable_sync;

    assign in_raw = {enable, valid_Epass, sensor3, sensor2, sensor1};

    always_ff @(posedge clk) begin
        if (reset_n) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sens_prev <= '0;
        end else begin
            sync_a    <= in_raw;
            sync_b    <= sync_a;
            sens_prev <= sync_b[2:0];
        end
    end

    assign s1_rise     = sync_b[0] & ~sens_prev[0];
    assign s2_rise     = sync_b[1] & ~sens_prev[1];
    assign s3_rise     = sync_b[2] & ~sens_prev[2];
    assign valid_sync  = sync_b[3];
    assign enable_sync = sync_b[4];

    // ---------------- state and datapath registers ----------------
    state_t                 state, state_next;
    logic [WIDTH_TIK-1:0]   tick;
    logic [3:0]             decade;
    logic [WIDTH_MS-1:0]    t;
    logic                   ms_pulse, pulse_10ms;
    logic                   epass, s2_seen;
    logic [DW-1:0]          rem, den, t_ext;
    logic [WIDTH_SPEED-1:0] quo, quo_next, speed_final;
    logic [CNT_W-1:0]       div_cnt;
    logic                   div_sat, div_ge, div_done, sat_now;
    logic [7:0]             rec_b1, rec_b2, rec_b1_div, tx_data;
    logic                   rec_valid;
    logic [1:0]             byte_idx;
    logic                   meas_start, go_divide, timeout_hit;
    logic                   tx_start, tx_ready, tx_busy;

    assign ms_pulse    = (tick == WIDTH_TIK'(TICKS_PER_MS - 1));
    assign pulse_10ms  = ms_pulse && (decade == 4'd9);
    assign timeout_hit = (t == T_MAX);
    assign go_divide   = (state == ST_TIMING) && !timeout_hit && s3_rise;

    // Anything that would not fit in WIDTH_SPEED bits (including t == 0)
    // saturates, so the remaining quotient needs only WIDTH_SPEED steps.
    assign t_ext   = DW'(t);
    assign sat_now = (DW'(DIST_CONST) >= (t_ext << WIDTH_SPEED));

    assign div_done = (state == ST_DIVIDE) && (div_sat || (div_cnt == '0));

    always_comb begin
        div_ge   = (rem >= den);
        quo_next = quo;
        if (div_ge) begin
            quo_next[div_cnt] = 1'b1;
        end
    end

    assign speed_final = div_sat ? SPEED_SAT : quo_next;
    assign rec_b1_div  = build_byte1(epass, 1'b0,
                                     speed_final[REC_SPEED_LO_W +: REC_SPEED_HI_W]);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        meas_start = 1'b0;
        tx_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s1_rise) begin
                    state_next = ST_TIMING;
                    meas_start = 1'b1;
                end else if (enable_sync && rec_valid) begin
                    state_next = ST_SEND;
                end
            end
            ST_TIMING: begin
                if (timeout_hit) begin
                    state_next = ST_SEND;
                end else if (s3_rise) begin
                    state_next = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (byte_idx != 2'(REC_BYTES)) begin
                    tx_start = tx_ready;
                end else if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            tick      <= '0;
            decade    <= '0;
            t         <= '0;
            epass     <= 1'b0;
            s2_seen   <= 1'b0;
            rem       <= '0;
            den       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            div_sat   <= 1'b0;
            rec_b1    <= '0;
            rec_b2    <= '0;
            rec_valid <= 1'b0;
            byte_idx  <= '0;
        end else begin
            // timebase: 1 ms ticks, 10 ms decade, t in 10 ms units
            if (meas_start) begin
                tick   <= '0;
                decade <= '0;
                t      <= '0;
            end else if (state == ST_TIMING) begin
                tick <= ms_pulse ? '0 : tick + WIDTH_TIK'(1);
                if (ms_pulse) begin
                    decade <= (decade == 4'd9) ? 4'd0 : decade + 4'd1;
                end
                if (pulse_10ms && !timeout_hit) begin
                    t <= t + WIDTH_MS'(1);
                end
            end

            // only the first sensor2 rise of a measurement samples the tag
            if (meas_start) begin
                epass   <= 1'b0;
                s2_seen <= 1'b0;
            end else if ((state == ST_TIMING) && s2_rise && !s2_seen) begin
                epass   <= valid_sync;
                s2_seen <= 1'b1;
            end

            // restoring divider, one quotient bit per cycle from the MSB
            if (go_divide) begin
                rem     <= DW'(DIST_CONST);
                den     <= t_ext << (WIDTH_SPEED - 1);
                quo     <= '0;
                div_cnt <= CNT_W'(WIDTH_SPEED - 1);
                div_sat <= sat_now;
            end else if ((state == ST_DIVIDE) && !div_sat) begin
                if (div_ge) begin
                    rem <= rem - den;
                end
                quo <= quo_next;
                den <= den >> 1;
                if (div_cnt != '0) begin
                    div_cnt <= div_cnt - CNT_W'(1);
                end
            end

            if (div_done) begin
                rec_b1    <= rec_b1_div;
                rec_b2    <= speed_final[REC_SPEED_LO_W-1:0];
                rec_valid <= 1'b1;
            end else if ((state == ST_TIMING) && timeout_hit) begin
                rec_b1    <= build_byte1(epass, 1'b1, '0);
                rec_b2    <= '0;
                rec_valid <= 1'b1;
            end

            if (state != ST_SEND) begin
                byte_idx <= '0;
            end else if (tx_start) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        case (byte_idx)
            2'd0:    tx_data = REC_HEADER;
            2'd1:    tx_data = rec_b1;
            default: tx_data = rec_b2;
        endcase
    end

    speed_trap_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tx_start),
        .data    (tx_data),
        .ready   (tx_ready),
        .busy    (tx_busy),
        .txd     (serial_data_out)
    );

endmodule

// File: tb/tb_speed_trap_top.sv
// Directed bench for speed_trap_top. Runs with TICKS_PER_MS=5 (1 ms = 5 clk,
// 10 ms = 50 clk) and CLKS_PER_BIT=8 so full measurements stay short.
module tb_speed_trap_top;

    localparam int TPM = 5;
    localparam int BIT = 8;
    localparam int MS  = TPM;

    logic clk = 1'b0;
    logic reset_n;
    logic sensor1, sensor2, sensor3, valid_Epass, enable;
    logic serial_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    speed_trap_top #(
        .TICKS_PER_MS (TPM),
        .CLKS_PER_BIT (BIT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor1         (sensor1),
        .sensor2         (sensor2),
        .sensor3         (sensor3),
        .valid_Epass     (valid_Epass),
        .enable          (enable),
        .serial_data_out (serial_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        n_tests++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, then samples mid-bit.
    task automatic rx_byte(input int budget, output logic [7:0] b, output int waited,
                           output bit ok);
        waited = 0;
        ok     = 1'b0;
        b      = '0;
        while (serial_data_out !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (serial_data_out !== 1'b0) return;
        cyc(BIT / 2);
        for (int i = 0; i < 8; i++) begin
            cyc(BIT);
            b[i] = serial_data_out;
        end
        cyc(BIT);
        ok = (serial_data_out === 1'b1);
    endtask

    task automatic rx_record(input string tag, input int budget, input logic [7:0] e1,
                             input logic [7:0] e2, input int lat_lo, input int lat_hi);
        logic [7:0] b;
        int  w0, w;
        bit  ok, frame_ok;
        frame_ok = 1'b1;
        rx_byte(budget, b, w0, ok);
        frame_ok &= ok;
        check({tag, "_hdr"}, 32'(b), 32'hA5);
        rx_byte(BIT, b, w, ok);
        frame_ok &= ok;
        check({tag, "_byte1"}, 32'(b), 32'(e1));
        rx_byte(BIT, b, w, ok);
        frame_ok &= ok;
        check({tag, "_byte2"}, 32'(b), 32'(e2));
        check({tag, "_framing"}, 32'(frame_ok), 32'd1);
        check_range({tag, "_latency"}, w0, lat_lo, lat_hi);
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (serial_data_out === 1'b0) lows++;
        end
    endtask

    task automatic sensors_off();
        sensor1 = 1'b0;
        sensor2 = 1'b0;
        sensor3 = 1'b0;
        valid_Epass = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int  w, lows;
        bit  ok;

        reset_n = 1'b1;
        enable  = 1'b0;
        sensors_off();
        cyc(5);
        check("reset_line_idle", 32'(serial_data_out), 32'd1);
        reset_n = 1'b0;
        cyc(5);

        // no stored record yet: enable must be ignored
        enable = 1'b1;
        count_low(150, lows);
        enable = 1'b0;
        check("enable_without_record", 32'(lows), 32'd0);

        // pass 1: s2 at 430 ms with e-pass, later second s2 rise without it,
        // s3 at 1205 ms -> t=120, speed 600
        sensor1 = 1'b1;
        cyc(430 * MS - 1);
        valid_Epass = 1'b1;
        cyc(1);
        sensor2 = 1'b1;
        cyc(850);
        sensor2 = 1'b0;
        valid_Epass = 1'b0;
        cyc(500);
        sensor2 = 1'b1;
        cyc(2525);
        sensor3 = 1'b1;
        rx_record("pass1", 40, 8'h82, 8'h58, 1, 24);
        sensors_off();
        cyc(100);

        // pass 2: sensor1 re-rises mid-measurement (ignored), s2 at 190 ms,
        // s3 at 605 ms -> t=60, speed 1200
        sensor1 = 1'b1;
        cyc(100 * MS);
        sensor1 = 1'b0;
        cyc(50 * MS);
        sensor1 = 1'b1;
        cyc(40 * MS - 1);
        valid_Epass = 1'b1;
        cyc(1);
        sensor2 = 1'b1;
        cyc(415 * MS);
        sensor3 = 1'b1;
        rx_record("pass2", 40, 8'h84, 8'hB0, 1, 24);
        sensors_off();
        cyc(100);

        // no e-pass, same timing as pass 1
        sensor1 = 1'b1;
        cyc(430 * MS);
        sensor2 = 1'b1;
        cyc(775 * MS);
        sensor3 = 1'b1;
        rx_record("no_epass", 40, 8'h02, 8'h58, 1, 24);
        sensors_off();
        cyc(100);

        // timeout: t reaches 511 at 511*50 cycles after the measurement starts
        sensor1 = 1'b1;
        rx_record("timeout", 26000, 8'h40, 8'h00, 25540, 25570);
        sensors_off();
        cyc(100);

        // saturation: sensor3 within the first 10 ms -> t=0
        sensor1 = 1'b1;
        cyc(20);
        sensor3 = 1'b1;
        rx_record("saturate", 40, 8'h3F, 8'hFF, 1, 24);
        sensors_off();
        cyc(100);

        // resend of the stored record, exactly once for a short request
        fork
            begin
                enable = 1'b1;
                cyc(4);
                enable = 1'b0;
            end
            rx_record("resend", 40, 8'h3F, 8'hFF, 1, 12);
        join
        count_low(300, lows);
        check("resend_once", 32'(lows), 32'd0);

        // reset in the middle of byte 1 of a record (t=60, epass=0 -> 0x04)
        sensor1 = 1'b1;
        cyc(605 * MS);
        sensor3 = 1'b1;
        rx_byte(40, b, w, ok);
        check("rst_case_hdr", 32'(b), 32'hA5);
        w = 0;
        while (serial_data_out !== 1'b0 && w < BIT) begin
            @(negedge clk);
            w++;
        end
        cyc(20);
        check("rst_line_low_before", 32'(serial_data_out), 32'd0);
        reset_n = 1'b1;
        sensors_off();
        cyc(1);
        check("rst_line_high_next_cycle", 32'(serial_data_out), 32'd1);
        cyc(2);
        reset_n = 1'b0;
        enable  = 1'b1;
        count_low(400, lows);
        enable  = 1'b0;
        check("rst_no_bytes_no_resend", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
